tt_sweep_ctrl: RTL and testbench

Sequencer for a 7-input majority-gate classification network under test. On a start request it enumerates all 128 input patterns through the evaluator, one per cycle, and collects the returned output bits into a 128-bit truth table. It then reports the ones-count, a mismatch count against an expected table, and the first mismatching row. It sits between the classification test harness (start, expected table, results) and the combinational or pipelined evaluator network (pattern out, function bit in).

---
 rtl/tt_sweep_pkg.sv | 26 ++
 rtl/eval_lat_pipe.sv | 43 ++++
 rtl/tt_sweep_ctrl.sv | 115 +++++++++++
 tb/tb_tt_sweep_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared constants and types for the truth-table sweep controller
package tt_sweep_pkg;

  localparam int N_IN   = 7;
  localparam int N_ROWS = 128;

  typedef logic [N_IN-1:0] row_t;

  localparam row_t LAST_ROW = row_t'(N_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } tt_state_e;

  typedef struct packed {
    logic [N_ROWS-1:0] tt;
    logic [7:0]        ones;
    logic [7:0]        mis_cnt;
    logic              mis_any;
    row_t              mis_first;
  } tt_result_t;

endpackage

// File: rtl/eval_lat_pipe.sv
// rtl/eval_lat_pipe.sv - valid+row-index delay line matching the evaluator latency
module eval_lat_pipe
  import tt_sweep_pkg::*;
#(
  parameter int EVAL_LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic vld_i,
  input  row_t idx_i,
  output logic vld_o,
  output row_t idx_o
);

  if (EVAL_LAT == 0) begin : g_wire
    logic unused_w;
    assign unused_w = ^{clk, rst, flush_i};
    assign vld_o    = vld_i;
    assign idx_o    = idx_i;
  end else begin : g_pipe
    logic [EVAL_LAT-1:0] vld_q;
    row_t                idx_q [EVAL_LAT];

    always_ff @(posedge clk) begin
      if (rst || flush_i) begin
        vld_q <= '0;
        for (int i = 0; i < EVAL_LAT; i++) idx_q[i] <= '0;
      end else begin
        vld_q[0] <= vld_i;
        idx_q[0] <= idx_i;
        for (int i = 1; i < EVAL_LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
          idx_q[i] <= idx_q[i-1];
        end
      end
    end

    assign vld_o = vld_q[EVAL_LAT-1];
    assign idx_o = idx_q[EVAL_LAT-1];
  end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// rtl/tt_sweep_ctrl.sv - sweeps all 128 patterns through an evaluator and scores the truth table
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int EVAL_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [N_ROWS-1:0] exp_tt,
  output logic [N_IN-1:0]   x_o,
  output logic              x_vld_o,
  input  logic              f_i,
  output logic              busy,
  output logic              done,
  output logic [N_ROWS-1:0] tt_o,
  output logic [7:0]        ones_o,
  output logic [7:0]        mis_cnt_o,
  output logic              mis_any_o,
  output logic [N_IN-1:0]   mis_first_o
);

  tt_state_e         state_q, state_d;
  row_t              idx_q, idx_d;
  logic [N_ROWS-1:0] exp_q, exp_d;
  tt_result_t        res_q, res_d;

  logic cap_vld;
  row_t cap_idx;
  logic flush;
  logic accept;

  assign flush  = abort && (state_q == SWEEP || state_q == DRAIN);
  assign accept = (state_q == IDLE) && start;

  eval_lat_pipe #(.EVAL_LAT(EVAL_LAT)) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .vld_i   (x_vld_o),
    .idx_i   (idx_q),
    .vld_o   (cap_vld),
    .idx_o   (cap_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          idx_d   = '0;
          exp_d   = exp_tt;
        end
      end
      SWEEP: begin
        // Index parks at the last row so x_o holds 127 through DRAIN.
        if (idx_q == LAST_ROW) state_d = (EVAL_LAT == 0) ? DONE : DRAIN;
        else                   idx_d   = idx_q + row_t'(1);
      end
      DRAIN: begin
        if (cap_vld && cap_idx == LAST_ROW) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    res_d = res_q;
    if (accept) begin
      res_d = '0;
    end else if (cap_vld && !flush) begin
      res_d.tt[cap_idx] = f_i;
      if (f_i) res_d.ones = res_q.ones + 8'd1;
      if (f_i != exp_q[cap_idx]) begin
        res_d.mis_cnt = res_q.mis_cnt + 8'd1;
        // Rows arrive in ascending order, so the first hit is the lowest row.
        if (!res_q.mis_any) begin
          res_d.mis_any   = 1'b1;
          res_d.mis_first = cap_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
    end
  end

  assign x_o         = idx_q;
  assign x_vld_o     = (state_q == SWEEP);
  assign busy        = (state_q == SWEEP) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign tt_o        = res_q.tt;
  assign ones_o      = res_q.ones;
  assign mis_cnt_o   = res_q.mis_cnt;
  assign mis_any_o   = res_q.mis_any;
  assign mis_first_o = res_q.mis_first;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb/tb_tt_sweep_ctrl.sv - scoreboard bench driving EVAL_LAT 0, 1 and 2 instances in lockstep
module tb_tt_sweep_ctrl;

  typedef struct {
    int           fsel;
    logic [127:0] exp_tt;
    logic [127:0] tt;
    int           ones;
    int           mis;
    logic         any;
    int           first;
  } vec_t;

  typedef struct {
    logic [127:0] tt;
    int           ones;
    int           mis;
    logic         any;
    int           first;
    int           done_cyc;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] exp_tt = '0;
  int           fsel = 0;
  int           cyc = 0;

  logic [6:0]   x_w     [3];
  logic         xv_w    [3];
  logic         f_w     [3];
  logic         busy_w  [3];
  logic         done_w  [3];
  logic [127:0] tt_w    [3];
  logic [7:0]   ones_w  [3];
  logic [7:0]   mis_w   [3];
  logic         any_w   [3];
  logic [6:0]   first_w [3];

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt [3];
  sb_t sb0[$];
  sb_t sb1[$];
  sb_t sb2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic maj7(input logic [6:0] x);
    int c;
    c = 0;
    for (int i = 0; i < 7; i++) c += int'(x[i]);
    return c >= 4;
  endfunction

  function automatic logic fn(input int sel, input logic [6:0] x);
    case (sel)
      0:       return x[0];
      1:       return &x;
      2:       return maj7(x);
      3:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tt_sweep_ctrl #(.EVAL_LAT(g)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .exp_tt      (exp_tt),
      .x_o         (x_w[g]),
      .x_vld_o     (xv_w[g]),
      .f_i         (f_w[g]),
      .busy        (busy_w[g]),
      .done        (done_w[g]),
      .tt_o        (tt_w[g]),
      .ones_o      (ones_w[g]),
      .mis_cnt_o   (mis_w[g]),
      .mis_any_o   (any_w[g]),
      .mis_first_o (first_w[g])
    );
    if (g == 0) begin : g_comb
      assign f_w[g] = fn(fsel, x_w[g]);
    end else begin : g_lat
      logic [1:0] fp;
      always @(posedge clk) fp <= {fp[0], fn(fsel, x_w[g])};
      assign f_w[g] = fp[g-1];
    end
  end

  task automatic chk(input string name, input int k, input logic [127:0] act, input logic [127:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h want %h", name, k, act, expv);
    end
  endtask

  task automatic check_sb(input int k, input sb_t e);
    chk("done_cycle", k, cyc, e.done_cyc);
    chk("tt", k, tt_w[k], e.tt);
    chk("ones", k, ones_w[k], e.ones);
    chk("mis_cnt", k, mis_w[k], e.mis);
    chk("mis_any", k, any_w[k], e.any);
    chk("mis_first", k, first_w[k], e.first);
  endtask

  sb_t  mon_e;
  logic mon_got;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_w[k] === 1'b1) begin
        done_cnt[k]++;
        mon_got = 1'b0;
        case (k)
          0: if (sb0.size() > 0) begin mon_e = sb0.pop_front(); mon_got = 1'b1; end
          1: if (sb1.size() > 0) begin mon_e = sb1.pop_front(); mon_got = 1'b1; end
          default: if (sb2.size() > 0) begin mon_e = sb2.pop_front(); mon_got = 1'b1; end
        endcase
        if (mon_got) check_sb(k, mon_e);
        else         chk("unexpected_done", k, 1, 0);
      end
    end
  end

  task automatic push_exp(input vec_t v, input int base, input int m);
    sb_t e;
    e.tt = v.tt; e.ones = v.ones; e.mis = v.mis; e.any = v.any; e.first = v.first;
    e.done_cyc = base + 129 + m * 130; sb0.push_back(e);
    e.done_cyc = base + 130 + m * 131; sb1.push_back(e);
    e.done_cyc = base + 131 + m * 132; sb2.push_back(e);
  endtask

  task automatic clear_sb();
    sb0.delete(); sb1.delete(); sb2.delete();
  endtask

  task automatic run_start(input vec_t v, output int base);
    @(negedge clk);
    fsel = v.fsel;
    exp_tt = v.exp_tt;
    base = cyc;
    push_exp(v, base, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy_w[0] && !busy_w[1] && !busy_w[2] && !done_w[0] && !done_w[1] && !done_w[2]
          && sb0.size() == 0 && sb1.size() == 0 && sb2.size() == 0) break;
    end
    chk(name, 0, i < 400, 1);
  endtask

  task automatic chk_reset();
    for (int k = 0; k < 3; k++) begin
      chk("rst_x", k, x_w[k], 0);
      chk("rst_xvld", k, xv_w[k], 0);
      chk("rst_busy", k, busy_w[k], 0);
      chk("rst_done", k, done_w[k], 0);
      chk("rst_tt", k, tt_w[k], 0);
      chk("rst_ones", k, ones_w[k], 0);
      chk("rst_mis", k, mis_w[k], 0);
      chk("rst_any", k, any_w[k], 0);
      chk("rst_first", k, first_w[k], 0);
    end
  endtask

  vec_t         vt [7];
  logic [127:0] aa;
  logic [127:0] gold;
  logic [127:0] top1;
  int           base;
  int           dc [3];

  initial begin
    for (int k = 0; k < 3; k++) done_cnt[k] = 0;
    aa = {16{8'hAA}};
    top1 = '0;
    top1[127] = 1'b1;
    for (int i = 0; i < 128; i++) gold[i] = maj7(7'(i));

    vt[0] = '{0, aa,           aa,    64, 0,   1'b0, 0};
    vt[1] = '{1, '0,           top1,  1,  1,   1'b1, 127};
    vt[2] = '{2, gold ^ (128'd1 << 5) ^ (128'd1 << 90), gold, 64, 2, 1'b1, 5};
    vt[3] = '{0, ~aa,          aa,    64, 128, 1'b1, 0};
    vt[4] = '{1, '1,           top1,  1,  127, 1'b1, 0};
    vt[5] = '{3, '0,           '0,    0,  0,   1'b0, 0};
    vt[6] = '{4, '1,           '1,    128, 0,  1'b0, 0};

    repeat (3) @(negedge clk);
    chk_reset();
    rst = 1'b0;

    for (int t = 0; t < 7; t++) begin
      run_start(vt[t], base);
      wait_idle("vec_timeout");
    end

    // abort in cycle 40, restart two cycles later
    for (int k = 0; k < 3; k++) dc[k] = done_cnt[k];
    run_start(vt[2], base);
    while (cyc < base + 40) @(negedge clk);
    abort = 1'b1;
    clear_sb();
    @(negedge clk);
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("abort_busy", k, busy_w[k], 0);
      chk("abort_xvld", k, xv_w[k], 0);
      chk("abort_nodone", k, done_cnt[k], dc[k]);
    end
    run_start(vt[2], base);
    wait_idle("abort_restart_timeout");

    // start pulses in cycles 10 and 100 are ignored
    for (int k = 0; k < 3; k++) dc[k] = done_cnt[k];
    run_start(vt[1], base);
    while (cyc < base + 10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < base + 100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ignored_start_timeout");
    for (int k = 0; k < 3; k++) chk("one_done", k, done_cnt[k] - dc[k], 1);

    // reset mid-sweep
    run_start(vt[2], base);
    while (cyc < base + 60) @(negedge clk);
    rst = 1'b1;
    clear_sb();
    @(negedge clk);
    rst = 1'b0;
    chk_reset();

    // start held high: three back-to-back sweeps on every instance
    for (int k = 0; k < 3; k++) dc[k] = done_cnt[k];
    @(negedge clk);
    fsel = vt[0].fsel;
    exp_tt = vt[0].exp_tt;
    base = cyc;
    for (int m = 0; m < 3; m++) push_exp(vt[0], base, m);
    start = 1'b1;
    while (cyc < base + 265) @(negedge clk);
    start = 1'b0;
    wait_idle("held_start_timeout");
    for (int k = 0; k < 3; k++) chk("held_done_cnt", k, done_cnt[k] - dc[k], 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
